sys1_rom_loader: RTL

Download-side front end for the SEGA System 1 core. Sits between the HPS ioctl download stream and the game core: routes ROM bytes to the core's ROM write port and captures the SYSMODE byte and the eight DIP-switch bytes. Owns the core reset sequencing around a ROM download, holding the core in reset while the ROM image loads and for a fixed stretch afterwards. Optionally keeps a running checksum and byte count of the ROM image for debug and bring-up.

---
 rtl/sys1_pkg.sv | 33 +++
 rtl/sys1_reset_stretch.sv | 62 ++++++
 rtl/sys1_rom_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sys1_pkg.sv
// sys1_pkg: shared types and constants for the SEGA System 1 download front end.
//   ldr_state_t       - loader state machine encoding
//   IDX_SYSMODE/DSW   - ioctl_index values of the SYSMODE and DIP-switch streams
//   SYSMODE_*         - bit positions inside the captured SYSMODE byte used by the core
//   hold_cnt_w()      - width of the post-download reset hold counter
package sys1_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StHold,
      StRun
   } ldr_state_t;

   localparam logic [7:0] IDX_SYSMODE = 8'd1;
   localparam logic [7:0] IDX_DSW     = 8'd254;

   localparam int unsigned SYSMODE_SYS2    = 0;
   localparam int unsigned SYSMODE_V       = 1;
   localparam int unsigned SYSMODE_H240    = 2;
   localparam int unsigned SYSMODE_WATER   = 3;
   localparam int unsigned SYSMODE_CCW     = 4;
   localparam int unsigned SYSMODE_SPINNER = 5;
   localparam int unsigned SYSMODE_HSDELAY = 6;

   // Enough bits to hold the value `hold`, never less than one.
   function automatic int unsigned hold_cnt_w(input int unsigned hold);
      int unsigned w;
      w = $clog2(hold + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sys1_reset_stretch.sv
// sys1_reset_stretch: keeps the core in reset while a ROM image loads and for RST_HOLD
// cycles after it ends.
//   clk_i, rst_i    - clock, asynchronous active-high reset
//   start_i         - download ended: load the hold counter and begin counting
//   abort_i         - new ROM download: drop any hold in progress and re-assert reset
//   done_o          - hold counter has reached zero (last HOLD cycle)
//   core_reset_o    - reset to the game core, high until a hold completes
module sys1_reset_stretch
   import sys1_pkg::*;
#(
   parameter int unsigned RST_HOLD = 4800
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic abort_i,
   output logic done_o,
   output logic core_reset_o
);

   localparam int unsigned CntW = hold_cnt_w(RST_HOLD);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            hold_q, hold_d;
   logic            released_q, released_d;

   always_comb begin
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      released_d = released_q;
      if (abort_i) begin
         hold_d     = 1'b0;
         released_d = 1'b0;
      end else if (start_i) begin
         hold_d = 1'b1;
         cnt_d  = CntW'(RST_HOLD);
      end else if (hold_q) begin
         if (cnt_q == '0) begin
            hold_d     = 1'b0;
            released_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         hold_q     <= 1'b0;
         released_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         released_q <= released_d;
      end
   end

   assign done_o       = hold_q && (cnt_q == '0) && !abort_i;
   assign core_reset_o = ~released_q;

endmodule

// File: rtl/sys1_rom_loader.sv
// sys1_rom_loader: HPS ioctl download front end for the SEGA System 1 core.
// Routes ROM bytes to the core ROM write port (registered), captures the SYSMODE byte
// and eight DIP-switch bytes, and sequences the core reset around ROM downloads.
//   clk_sys, reset             - 48 MHz clock, asynchronous active-high reset
//   ioctl_*                    - HPS download stream (download, wr, index, addr, dout)
//   rom_addr/rom_data/rom_we   - core ROM write port, one cycle after the ioctl write
//   sysmode, dsw               - captured SYSMODE byte and DIP bytes (byte n at [8n+7:8n])
//   core_reset, rom_loaded     - core reset and "a ROM image has been loaded" flag
// Optional feature, macro SYS1_ROM_CHECKSUM_EN: adds rom_sum (16-bit additive checksum)
// and rom_count (accepted ROM byte count), both cleared when a ROM download starts.
module sys1_rom_loader
   import sys1_pkg::*;
#(
   parameter int unsigned RST_HOLD  = 4800,
   parameter int unsigned ROM_INDEX = 0
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [24:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        rom_we,
   output logic [7:0]  sysmode,
   output logic [63:0] dsw,
   output logic        core_reset,
`ifdef SYS1_ROM_CHECKSUM_EN
   output logic [15:0] rom_sum,
   output logic [24:0] rom_count,
`endif
   output logic        rom_loaded
);

   localparam logic [7:0] RomIdx = 8'(ROM_INDEX);

   ldr_state_t  state_q, state_d;
   logic        dl_q;
   logic [7:0]  cur_index_q;
   logic        cur_valid_q;
   logic        rom_we_q;
   logic [24:0] rom_addr_q;
   logic [7:0]  rom_data_q;
   logic [7:0]  sysmode_q;
   logic [63:0] dsw_q, dsw_d;
   logic        rom_loaded_q;

   logic dl_rise, dl_fall, rom_rise;
   logic wr_ok, rom_wr, sys_wr, dsw_wr;
   logic hold_start, hold_done;

   assign dl_rise  = ioctl_download & ~dl_q;
   assign dl_fall  = ~ioctl_download & dl_q;
   assign rom_rise = dl_rise && (ioctl_index == RomIdx);

   // cur_valid_q gates writes until an index has been latched since reset.
   assign wr_ok  = ioctl_wr & ioctl_download & cur_valid_q;
   assign rom_wr = wr_ok && (cur_index_q == RomIdx);
   assign sys_wr = wr_ok && (cur_index_q == IDX_SYSMODE) && (ioctl_addr == '0);
   assign dsw_wr = wr_ok && (cur_index_q == IDX_DSW) && (ioctl_addr[24:3] == '0);

   always_comb begin
      state_d    = state_q;
      hold_start = 1'b0;
      unique case (state_q)
         StIdle: if (rom_rise) state_d = StLoad;
         StLoad: begin
            if (dl_fall) begin
               state_d    = StHold;
               hold_start = 1'b1;
            end
         end
         StHold: begin
            if (rom_rise)       state_d = StLoad;
            else if (hold_done) state_d = StRun;
         end
         StRun:  if (rom_rise) state_d = StLoad;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dsw_d = dsw_q;
      if (dsw_wr) dsw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
   end

   sys1_reset_stretch #(
      .RST_HOLD(RST_HOLD)
   ) u_reset_stretch (
      .clk_i       (clk_sys),
      .rst_i       (reset),
      .start_i     (hold_start),
      .abort_i     (rom_rise),
      .done_o      (hold_done),
      .core_reset_o(core_reset)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         // Reset as "already high" so a download still running when reset releases
         // is not taken for a fresh start.
         dl_q         <= 1'b1;
         cur_index_q  <= '0;
         cur_valid_q  <= 1'b0;
         rom_we_q     <= 1'b0;
         rom_addr_q   <= '0;
         rom_data_q   <= '0;
         sysmode_q    <= '0;
         dsw_q        <= '0;
         rom_loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dl_q     <= ioctl_download;
         rom_we_q <= rom_wr;
         dsw_q    <= dsw_d;
         if (dl_rise) begin
            cur_index_q <= ioctl_index;
            cur_valid_q <= 1'b1;
         end
         if (rom_wr) begin
            rom_addr_q <= ioctl_addr;
            rom_data_q <= ioctl_dout;
         end
         if (sys_wr) sysmode_q <= ioctl_dout;
         if ((state_q == StHold) && hold_done) rom_loaded_q <= 1'b1;
      end
   end

`ifdef SYS1_ROM_CHECKSUM_EN
   logic [15:0] sum_q;
   logic [24:0] count_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sum_q   <= '0;
         count_q <= '0;
      end else if (rom_rise) begin
         sum_q   <= '0;
         count_q <= '0;
      end else if (rom_wr) begin
         sum_q   <= sum_q + {8'h00, ioctl_dout};
         count_q <= count_q + 25'd1;
      end
   end

   assign rom_sum   = sum_q;
   assign rom_count = count_q;
`endif

   assign rom_addr   = rom_addr_q;
   assign rom_data   = rom_data_q;
   assign rom_we     = rom_we_q;
   assign sysmode    = sysmode_q;
   assign dsw        = dsw_q;
   assign rom_loaded = rom_loaded_q;

endmodule
